// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode, forwarding-source and ALU-side signals of the ID/EX stage
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW = 5
);
    logic id_valid, id_ready, id_uses_rs1, id_uses_rs2;
    logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [DATA_WIDTH-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [3:0] id_alu_ctrl;
    logic id_srca_pc, id_srcb_imm, id_reg_write, id_mem_read, id_mem_write;
    logic flush, ex_stall;
    logic [REG_AW-1:0] exm_rd_addr, mwb_rd_addr;
    logic exm_reg_write, mwb_reg_write;
    logic [DATA_WIDTH-1:0] exm_result, mwb_result;
    logic [DATA_WIDTH-1:0] ALUop1, ALUop2, ex_store_data;
    logic [3:0] ALUctrl;
    logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [REG_AW-1:0] ex_rd_addr;
    modport master (
        output id_valid, id_uses_rs1, id_uses_rs2, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_ctrl, id_srca_pc, id_srcb_imm,
               id_reg_write, id_mem_read, id_mem_write, flush, ex_stall,
               exm_rd_addr, exm_reg_write, exm_result, mwb_rd_addr, mwb_reg_write, mwb_result,
        input  id_ready, ALUop1, ALUop2, ALUctrl, ex_valid, ex_rd_addr, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data
    );
    modport slave (
        input  id_valid, id_uses_rs1, id_uses_rs2, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_ctrl, id_srca_pc, id_srcb_imm,
               id_reg_write, id_mem_read, id_mem_write, flush, ex_stall,
               exm_rd_addr, exm_reg_write, exm_result, mwb_rd_addr, mwb_reg_write, mwb_result,
        output id_ready, ALUop1, ALUop2, ALUctrl, ex_valid, ex_rd_addr, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW = 5
) (
    input logic clk,
    input logic rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic valid, srca_pc, srcb_imm, reg_write, mem_read, mem_write;
        logic [3:0] alu_ctrl;
        logic [REG_AW-1:0] rs1_addr, rs2_addr, rd_addr;
        logic [DATA_WIDTH-1:0] rs1_data, rs2_data, imm, pc;
    } ex_t;
    ex_t ex_q, ex_d, cap, bub;
    logic load_use;
    logic [DATA_WIDTH-1:0] fwd1, fwd2;
    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read && ex_q.rd_addr != '0 &&
                   ((bus.id_uses_rs1 && ex_q.rd_addr == bus.id_rs1_addr) ||
                    (bus.id_uses_rs2 && ex_q.rd_addr == bus.id_rs2_addr));
        cap.valid = bus.id_valid;
        cap.srca_pc = bus.id_srca_pc;
        cap.srcb_imm = bus.id_srcb_imm;
        cap.reg_write = bus.id_valid && bus.id_reg_write;
        cap.mem_read = bus.id_valid && bus.id_mem_read;
        cap.mem_write = bus.id_valid && bus.id_mem_write;
        cap.alu_ctrl = bus.id_valid ? bus.id_alu_ctrl : 4'd0;
        cap.rs1_addr = bus.id_rs1_addr;
        cap.rs2_addr = bus.id_rs2_addr;
        cap.rd_addr = bus.id_rd_addr;
        // a result retiring this very edge has not reached the register-file read data yet
        cap.rs1_data = (bus.mwb_reg_write && bus.mwb_rd_addr != '0 && bus.mwb_rd_addr == bus.id_rs1_addr)
                       ? bus.mwb_result : bus.id_rs1_data;
        cap.rs2_data = (bus.mwb_reg_write && bus.mwb_rd_addr != '0 && bus.mwb_rd_addr == bus.id_rs2_addr)
                       ? bus.mwb_result : bus.id_rs2_data;
        cap.imm = bus.id_imm;
        cap.pc = bus.id_pc;
        bub = ex_q;
        bub.valid = 1'b0;
        bub.reg_write = 1'b0;
        bub.mem_read = 1'b0;
        bub.mem_write = 1'b0;
        bub.alu_ctrl = 4'd0;
        ex_d = bus.flush ? bub : bus.ex_stall ? ex_q : load_use ? bub : cap;
        fwd1 = (bus.exm_reg_write && bus.exm_rd_addr != '0 && bus.exm_rd_addr == ex_q.rs1_addr) ? bus.exm_result :
               (bus.mwb_reg_write && bus.mwb_rd_addr != '0 && bus.mwb_rd_addr == ex_q.rs1_addr) ? bus.mwb_result :
               ex_q.rs1_data;
        fwd2 = (bus.exm_reg_write && bus.exm_rd_addr != '0 && bus.exm_rd_addr == ex_q.rs2_addr) ? bus.exm_result :
               (bus.mwb_reg_write && bus.mwb_rd_addr != '0 && bus.mwb_rd_addr == ex_q.rs2_addr) ? bus.mwb_result :
               ex_q.rs2_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else ex_q <= ex_d;
    end
    assign bus.id_ready = !bus.ex_stall && !load_use;
    assign bus.ALUop1 = ex_q.srca_pc ? ex_q.pc : fwd1;
    assign bus.ALUop2 = ex_q.srcb_imm ? ex_q.imm : fwd2;
    assign bus.ex_store_data = fwd2;
    assign bus.ALUctrl = ex_q.alu_ctrl;
    assign bus.ex_valid = ex_q.valid;
    assign bus.ex_rd_addr = ex_q.rd_addr;
    assign bus.ex_reg_write = ex_q.valid && ex_q.reg_write;
    assign bus.ex_mem_read = ex_q.valid && ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.valid && ex_q.mem_write;
endmodule
